// File: rtl/serial_operand_feeder_if.sv
// Handshake bundle between an operand producer and serial_operand_feeder.
// Parallel operand side (in_*) and serial bit-pair side (bit_*).
// Optional macro SERIAL_FEEDER_SUB_EN adds the in_sub request bit.
interface serial_operand_feeder_if #(
  parameter int unsigned N = 4
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N:0]   in_a;
  logic [N:0]   in_b;
`ifdef SERIAL_FEEDER_SUB_EN
  logic         in_sub;
`endif
  logic         bit_valid;
  logic         bit_ready;
  logic         bit_a;
  logic         bit_b;
  logic         bit_first;
  logic         bit_last;
  logic         bit_cin;
  logic         busy;

  // Producer / downstream-consumer side: drives operands and bit_ready.
  modport master (
    output in_valid,
    input  in_ready,
    output in_a,
    output in_b,
`ifdef SERIAL_FEEDER_SUB_EN
    output in_sub,
`endif
    input  bit_valid,
    output bit_ready,
    input  bit_a,
    input  bit_b,
    input  bit_first,
    input  bit_last,
    input  bit_cin,
    input  busy
  );

  // Feeder side.
  modport slave (
    input  in_valid,
    output in_ready,
    input  in_a,
    input  in_b,
`ifdef SERIAL_FEEDER_SUB_EN
    input  in_sub,
`endif
    output bit_valid,
    input  bit_ready,
    output bit_a,
    output bit_b,
    output bit_first,
    output bit_last,
    output bit_cin,
    output busy
  );

endinterface : serial_operand_feeder_if

// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: accepts a parallel operand pair and streams it to a
// bit-serial adder LSB first, one bit pair per accepted bit transfer.
// A new pair may be accepted on the last-bit transfer so words run without a
// bubble.
// Optional feature macro: SERIAL_FEEDER_SUB_EN -- adds in_sub; when set with
// the operands, B is inverted and carry-in is 1 on the first bit (A-B).
module serial_operand_feeder #(
  parameter int unsigned N = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_operand_feeder_if.slave bus
);

  localparam int unsigned W  = N + 1;
  localparam int unsigned CW = (N > 0) ? $clog2(N + 1) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e          state_q;
  state_e          state_d;

  logic [W-1:0]    sh_a_q;
  logic [W-1:0]    sh_b_q;
  logic [CW-1:0]   count_q;
  logic            first_q;
  logic            last_q;
  logic            cin_q;

  logic            load;
  logic            step;
  logic            clear;
  logic            in_ready_c;
  logic [W-1:0]    b_load_c;
  logic            cin_load_c;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath controls.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    step       = 1'b0;
    clear      = 1'b0;
    in_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bit_ready) begin
          if (last_q) begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
              load = 1'b1;
            end else begin
              clear   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            step = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand B as stored (inverted for subtraction) and first-bit carry-in.
  always_comb begin
    b_load_c   = bus.in_b;
    cin_load_c = 1'b0;
`ifdef SERIAL_FEEDER_SUB_EN
    if (bus.in_sub) begin
      b_load_c   = ~bus.in_b;
      cin_load_c = 1'b1;
    end
`endif
  end

  // Shift registers, bit counter and registered first/last/cin flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      count_q <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      cin_q   <= 1'b0;
    end else if (load) begin
      sh_a_q  <= bus.in_a;
      sh_b_q  <= b_load_c;
      count_q <= '0;
      first_q <= 1'b1;
      last_q  <= (N == 0);
      cin_q   <= cin_load_c;
    end else if (step) begin
      sh_a_q  <= sh_a_q >> 1;
      sh_b_q  <= sh_b_q >> 1;
      count_q <= count_q + CW'(1);
      first_q <= 1'b0;
      last_q  <= ((count_q + CW'(1)) == CW'(N));
      cin_q   <= 1'b0;
    end else if (clear) begin
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      count_q <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      cin_q   <= 1'b0;
    end
  end

  // Outputs: all taken from flops except the ready handshake.
  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.bit_valid = (state_q == SHIFT);
  assign bus.bit_a     = sh_a_q[0];
  assign bus.bit_b     = sh_b_q[0];
  assign bus.bit_first = first_q;
  assign bus.bit_last  = last_q;
  assign bus.bit_cin   = cin_q;

endmodule : serial_operand_feeder

// File: tb/tb_serial_operand_feeder.sv
// Directed self-checking bench for serial_operand_feeder (N=4).
// Build with +define+SERIAL_FEEDER_SUB_EN to also exercise subtraction.
module tb_serial_operand_feeder;

  localparam int unsigned N = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  serial_operand_feeder_if #(.N(N)) bus ();

  serial_operand_feeder #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output vector: valid, first, last, a, b, cin, busy, in_ready.
  function automatic logic [7:0] obs_vec();
    return {bus.bit_valid, bus.bit_first, bus.bit_last, bus.bit_a,
            bus.bit_b, bus.bit_cin, bus.busy, bus.in_ready};
  endfunction

  function automatic logic [7:0] exp_vec(input logic v, input logic f,
                                         input logic l, input logic a,
                                         input logic b, input logic c,
                                         input logic bz, input logic r);
    return {v, f, l, a, b, c, bz, r};
  endfunction

  localparam logic [7:0] IDLE_VEC = 8'b0000_0001;

  task automatic test_reset();
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.bit_ready  = 1'b0;
`ifdef SERIAL_FEEDER_SUB_EN
    bus.in_sub     = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs_vec(), IDLE_VEC);
    end
  endtask

  task automatic test_basic();
    logic [4:0] ea;
    logic [4:0] eb;
    logic [7:0] e;
    ea = 5'b01101;
    eb = 5'b01011;
    @(negedge clk);
    bus.in_a      = ea;
    bus.in_b      = eb;
    bus.in_valid  = 1'b1;
    bus.bit_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_accept: in_ready got %b expected 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      e = exp_vec(1'b1, i == 0, i == 4, ea[i], eb[i], 1'b0, 1'b1, i == 4);
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL basic_bit%0d: got %b expected %b", i, obs_vec(), e);
      end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (obs_vec() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL basic_idle: got %b expected %b", obs_vec(), IDLE_VEC);
    end
  endtask

  task automatic test_stall();
    logic [4:0] ea;
    logic [4:0] eb;
    logic [7:0] e;
    int idx;
    int stalls;
    int xfers;
    ea = 5'b01101;
    eb = 5'b01011;
    idx = 0;
    stalls = 0;
    xfers = 0;
    @(negedge clk);
    bus.in_a      = ea;
    bus.in_b      = eb;
    bus.in_valid  = 1'b1;
    bus.bit_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && idx < 5; cyc++) begin
      bus.bit_ready = !(idx == 2 && stalls < 3);
      #1;
      e = exp_vec(1'b1, idx == 0, idx == 4, ea[idx], eb[idx], 1'b0, 1'b1,
                  idx == 4 && bus.bit_ready);
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL stall_cyc%0d_bit%0d: got %b expected %b",
                 cyc, idx, obs_vec(), e);
      end
      if (bus.bit_ready) begin
        idx++;
        xfers++;
      end else begin
        stalls++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.bit_ready = 1'b1;
    #1;
    n_checks++;
    if (xfers !== 5 || stalls !== 3) begin
      n_fail++;
      $display("FAIL stall_count: got xfers=%0d stalls=%0d expected 5 and 3",
               xfers, stalls);
    end
    n_checks++;
    if (obs_vec() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL stall_idle: got %b expected %b", obs_vec(), IDLE_VEC);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] a1;
    logic [4:0] b1;
    logic [4:0] a2;
    logic [4:0] b2;
    logic [7:0] e;
    a1 = 5'b01101;
    b1 = 5'b01011;
    a2 = 5'b00011;
    b2 = 5'b00001;
    @(negedge clk);
    bus.in_a      = a1;
    bus.in_b      = b1;
    bus.in_valid  = 1'b1;
    bus.bit_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_a = a2;
    bus.in_b = b2;
    for (int i = 0; i < 5; i++) begin
      #1;
      e = exp_vec(1'b1, i == 0, i == 4, a1[i], b1[i], 1'b0, 1'b1, i == 4);
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL b2b_w1_bit%0d: got %b expected %b", i, obs_vec(), e);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_a     = 5'b11111;
    bus.in_b     = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      #1;
      e = exp_vec(1'b1, i == 0, i == 4, a2[i], b2[i], 1'b0, 1'b1, i == 4);
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL b2b_w2_bit%0d: got %b expected %b", i, obs_vec(), e);
      end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (obs_vec() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL b2b_idle: got %b expected %b", obs_vec(), IDLE_VEC);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] a2;
    logic [4:0] b2;
    logic [7:0] e;
    a2 = 5'b00011;
    b2 = 5'b00001;
    @(negedge clk);
    bus.in_a      = 5'b01101;
    bus.in_b      = 5'b01011;
    bus.in_valid  = 1'b1;
    bus.bit_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 5'b11111;
    bus.in_b     = 5'b11111;
    @(posedge clk);
    @(negedge clk);
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.bit_ready = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL midreset_idle: got %b expected %b", obs_vec(), IDLE_VEC);
    end
    @(negedge clk);
    bus.in_a     = a2;
    bus.in_b     = b2;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    e = exp_vec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs_vec() !== e) begin
      n_fail++;
      $display("FAIL midreset_restart: got %b expected %b", obs_vec(), e);
    end
    bus.bit_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      e = exp_vec(1'b1, i == 0, i == 4, a2[i], b2[i], 1'b0, 1'b1, i == 4);
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL midreset_bit%0d: got %b expected %b", i, obs_vec(), e);
      end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (obs_vec() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL midreset_end: got %b expected %b", obs_vec(), IDLE_VEC);
    end
  endtask

`ifdef SERIAL_FEEDER_SUB_EN
  task automatic test_sub();
    logic [4:0] ea;
    logic [4:0] eb;
    logic [4:0] ec;
    logic [7:0] e;
    ea = 5'b00110;
    eb = 5'b11101;
    ec = 5'b00001;
    @(negedge clk);
    bus.in_a      = 5'b00110;
    bus.in_b      = 5'b00010;
    bus.in_sub    = 1'b1;
    bus.in_valid  = 1'b1;
    bus.bit_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sub   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      e = exp_vec(1'b1, i == 0, i == 4, ea[i], eb[i], ec[i], 1'b1, i == 4);
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL sub_bit%0d: got %b expected %b", i, obs_vec(), e);
      end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (obs_vec() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL sub_idle: got %b expected %b", obs_vec(), IDLE_VEC);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_FEEDER_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_operand_feeder
